id_ctrl_pipe: RTL

Parametrised successor to the combinational ID-stage decoder. It decodes the instruction in IF/ID and detects load-use hazards against the instruction in EX. It registers the decoded control word into the ID/EX control slice, inserting bubbles on stall or flush. It sits between the IF/ID register and the EX stage and drives the PC and IF/ID write-enables.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 87 ++++++++
 rtl/id_ctrl_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the ID-stage control pipeline: opcodes, ALUOp codes,
// the decoded control word and the hazard FSM states.
package ctrl_pkg;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] BEQ    = 7'b1100011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

    typedef enum logic {
        RUN,
        STALL
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word, legality and which source
// registers the instruction actually reads.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl_bits,
    output logic              legal,
    output logic              use_rs1,
    output logic              use_rs2
);

    ctrl_word_t ctrl;

    always_comb begin
        ctrl    = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            R_TYPE: begin
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
            end
            LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                use_rs1         = 1'b1;
            end
            SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
            end
            BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
            end
            // Extended opcodes fall back to "unknown" when EXT_OPS is off.
            JAL: begin
                if (EXT_OPS != 0) begin
                    ctrl.jump      = 1'b1;
                    ctrl.reg_write = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            JALR: begin
                if (EXT_OPS != 0) begin
                    ctrl.jump      = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    use_rs1        = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            LUI: begin
                if (EXT_OPS != 0) begin
                    ctrl.alu_op    = ALU_LUI;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign ctrl_bits = ctrl;

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage control: decode, load-use hazard detection with a one-cycle
// stall FSM, and the ID/EX control register with bubble insertion.
module id_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int EXT_OPS = 1,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_instr,
    input  logic               flush,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               illegal
);

    logic [CTRL_W-1:0] dec_bits;
    ctrl_word_t        dec_p0;
    logic              legal_p0, use_rs1_p0, use_rs2_p0;
    logic [REG_AW-1:0] rs1_p0, rs2_p0, rd_p0;
    logic              hazard, stall_req, unused_instr;

    ctrl_state_e       state;
    logic              vld_p1;
    ctrl_word_t        ctrl_p1;
    logic [REG_AW-1:0] rd_p1;
    logic              illegal_p1;

    ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
        .opcode    (id_instr[6:0]),
        .ctrl_bits (dec_bits),
        .legal     (legal_p0),
        .use_rs1   (use_rs1_p0),
        .use_rs2   (use_rs2_p0)
    );

    assign dec_p0       = dec_bits;
    assign rd_p0        = id_instr[7 +: REG_AW];
    assign rs1_p0       = id_instr[15 +: REG_AW];
    assign rs2_p0       = id_instr[20 +: REG_AW];
    assign unused_instr = ^{id_instr[14:12], id_instr[31:25]};

    assign hazard = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) && id_valid &&
                    ((use_rs1_p0 && (rs1_p0 == rd_p1)) ||
                     (use_rs2_p0 && (rs2_p0 == rd_p1)));

    // While in STALL the load has moved on, so only RUN can request a stall.
    assign stall_req  = (state == RUN) && hazard && !flush;
    assign pc_write   = !stall_req;
    assign ifid_write = !stall_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else if (flush || state == STALL) begin
            state <= RUN;
        end else if (stall_req) begin
            state <= STALL;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (rst || flush || stall_req || !id_valid) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            rd_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else begin
            vld_p1     <= 1'b1;
            ctrl_p1    <= dec_p0;
            rd_p1      <= rd_p0;
            illegal_p1 <= !legal_p0;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_alu_op     = ALUOP_W'(ctrl_p1.alu_op);
    assign ex_alu_src    = ctrl_p1.alu_src;
    assign ex_branch     = ctrl_p1.branch;
    assign ex_jump       = ctrl_p1.jump;
    assign ex_mem_read   = ctrl_p1.mem_read;
    assign ex_mem_write  = ctrl_p1.mem_write;
    assign ex_reg_write  = ctrl_p1.reg_write;
    assign ex_mem_to_reg = ctrl_p1.mem_to_reg;
    assign ex_rd         = rd_p1;
    assign illegal       = illegal_p1;

endmodule
